// File: rtl/oh_pwrgate_seq_if.sv
// Handshake, config and power-control bundle for oh_pwrgate_seq.
// OH_PWRSEQ_RETENTION_EN adds the ret_save/ret_restore strobes.
interface oh_pwrgate_seq_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8
);
    logic          pwr_req_i;
    logic [DW-1:0] stagger_cfg_i;
    logic [DW-1:0] settle_cfg_i;
    logic          vdd_good_i;
    logic          pwr_ack_o;
    logic [N-1:0]  sw_en_o;
    logic          iso_en_o;
    logic          dom_reset_o;
    logic          busy_o;
    logic          err_o;
`ifdef OH_PWRSEQ_RETENTION_EN
    logic          ret_save_o;
    logic          ret_restore_o;
`endif

    modport slave (
        input  pwr_req_i, stagger_cfg_i, settle_cfg_i, vdd_good_i,
`ifdef OH_PWRSEQ_RETENTION_EN
        output ret_save_o, ret_restore_o,
`endif
        output pwr_ack_o, sw_en_o, iso_en_o, dom_reset_o, busy_o, err_o
    );

    modport master (
        output pwr_req_i, stagger_cfg_i, settle_cfg_i, vdd_good_i,
`ifdef OH_PWRSEQ_RETENTION_EN
        input  ret_save_o, ret_restore_o,
`endif
        input  pwr_ack_o, sw_en_o, iso_en_o, dom_reset_o, busy_o, err_o
    );
endinterface

// File: rtl/oh_pwrgate_seq.sv
// Staggered header-switch power-up/down sequencer with isolation and domain reset.
// OH_PWRSEQ_RETENTION_EN adds SAVE/RESTORE retention steps.
module oh_pwrgate_seq #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8
) (
    input logic              clk,
    input logic              reset,
    oh_pwrgate_seq_if.slave  bus
);

    typedef enum logic [3:0] {
        ST_OFF     = 4'd0,
        ST_RAMPUP  = 4'd1,
        ST_SETTLE  = 4'd2,
        ST_UNISO   = 4'd3,
        ST_ON      = 4'd4,
        ST_ISO     = 4'd5,
        ST_RAMPDN  = 4'd6
`ifdef OH_PWRSEQ_RETENTION_EN
        ,
        ST_SAVE    = 4'd7,
        ST_RESTORE = 4'd8
`endif
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  sw_en_q, sw_en_d;
    logic          iso_en_q, iso_en_d;
    logic          dom_reset_q, dom_reset_d;
    logic          pwr_ack_q, pwr_ack_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          rearm_q, rearm_d;
`ifdef OH_PWRSEQ_RETENTION_EN
    logic          ret_save_q, ret_save_d;
    logic          ret_restore_q, ret_restore_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_OFF;
            cnt_q       <= '0;
            sw_en_q     <= '0;
            iso_en_q    <= 1'b1;
            dom_reset_q <= 1'b1;
            pwr_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            rearm_q     <= 1'b0;
`ifdef OH_PWRSEQ_RETENTION_EN
            ret_save_q    <= 1'b0;
            ret_restore_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sw_en_q     <= sw_en_d;
            iso_en_q    <= iso_en_d;
            dom_reset_q <= dom_reset_d;
            pwr_ack_q   <= pwr_ack_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            rearm_q     <= rearm_d;
`ifdef OH_PWRSEQ_RETENTION_EN
            ret_save_q    <= ret_save_d;
            ret_restore_q <= ret_restore_d;
`endif
        end
    end

    // Next state and registered outputs; the sw_en thermometer grows from bit0, shrinks from the top
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sw_en_d     = sw_en_q;
        iso_en_d    = iso_en_q;
        dom_reset_d = dom_reset_q;
        pwr_ack_d   = pwr_ack_q;
        busy_d      = busy_q;
        err_d       = err_q;
        // After a timeout, a fresh start needs pwr_req to have been seen low
        rearm_d     = rearm_q | ~bus.pwr_req_i;
`ifdef OH_PWRSEQ_RETENTION_EN
        ret_save_d    = 1'b0;
        ret_restore_d = 1'b0;
`endif
        case (state_q)
            ST_OFF: begin
                if (bus.pwr_req_i && (!err_q || rearm_q)) begin
                    state_d = ST_RAMPUP;
                    sw_en_d = N'(1);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
            ST_RAMPUP: begin
                if (cnt_q == bus.stagger_cfg_i) begin
                    cnt_d = '0;
                    if (&sw_en_q) state_d = ST_SETTLE;
                    else          sw_en_d = (sw_en_q << 1) | N'(1);
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            ST_SETTLE: begin
                if (bus.vdd_good_i) begin
                    state_d  = ST_UNISO;
                    iso_en_d = 1'b0;
                end else if (cnt_q == bus.settle_cfg_i) begin
                    state_d = ST_RAMPDN;
                    err_d   = 1'b1;
                    rearm_d = 1'b0;
                    sw_en_d = sw_en_q >> 1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            ST_UNISO: begin
`ifdef OH_PWRSEQ_RETENTION_EN
                state_d       = ST_RESTORE;
                ret_restore_d = 1'b1;
`else
                state_d     = ST_ON;
                dom_reset_d = 1'b0;
                pwr_ack_d   = 1'b1;
                busy_d      = 1'b0;
`endif
            end
`ifdef OH_PWRSEQ_RETENTION_EN
            ST_RESTORE: begin
                state_d     = ST_ON;
                dom_reset_d = 1'b0;
                pwr_ack_d   = 1'b1;
                busy_d      = 1'b0;
            end
`endif
            ST_ON: begin
                if (!bus.pwr_req_i) begin
                    state_d     = ST_ISO;
                    iso_en_d    = 1'b1;
                    dom_reset_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            ST_ISO: begin
                cnt_d = '0;
`ifdef OH_PWRSEQ_RETENTION_EN
                state_d    = ST_SAVE;
                ret_save_d = 1'b1;
`else
                state_d = ST_RAMPDN;
                sw_en_d = sw_en_q >> 1;
`endif
            end
`ifdef OH_PWRSEQ_RETENTION_EN
            // First cycle strobes ret_save, second cycle is idle
            ST_SAVE: begin
                if (cnt_q == '0) begin
                    cnt_d = DW'(1);
                end else begin
                    state_d = ST_RAMPDN;
                    sw_en_d = sw_en_q >> 1;
                    cnt_d   = '0;
                end
            end
`endif
            ST_RAMPDN: begin
                if (cnt_q == bus.stagger_cfg_i) begin
                    cnt_d = '0;
                    if (sw_en_q == '0) begin
                        state_d   = ST_OFF;
                        pwr_ack_d = 1'b0;
                        busy_d    = 1'b0;
                    end else begin
                        sw_en_d = sw_en_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    assign bus.sw_en_o     = sw_en_q;
    assign bus.iso_en_o    = iso_en_q;
    assign bus.dom_reset_o = dom_reset_q;
    assign bus.pwr_ack_o   = pwr_ack_q;
    assign bus.busy_o      = busy_q;
    assign bus.err_o       = err_q;
`ifdef OH_PWRSEQ_RETENTION_EN
    assign bus.ret_save_o    = ret_save_q;
    assign bus.ret_restore_o = ret_restore_q;
`endif

endmodule

// File: tb/tb_oh_pwrgate_seq.sv
// Directed self-checking bench for oh_pwrgate_seq (N=4, DW=8).
// Honors OH_PWRSEQ_RETENTION_EN when the design is built with it.
module tb_oh_pwrgate_seq;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    oh_pwrgate_seq_if #(.N(4), .DW(8)) bus ();

    oh_pwrgate_seq #(.N(4), .DW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.pwr_req_i     = 1'b0;
        bus.vdd_good_i    = 1'b0;
        bus.stagger_cfg_i = 8'd0;
        bus.settle_cfg_i  = 8'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.sw_en_o !== 4'b0000) begin errors++; $display("FAIL reset_sw_en got %b exp 0000", bus.sw_en_o); end
        checks++; if (bus.iso_en_o !== 1'b1) begin errors++; $display("FAIL reset_iso_en got %b exp 1", bus.iso_en_o); end
        checks++; if (bus.dom_reset_o !== 1'b1) begin errors++; $display("FAIL reset_dom_reset got %b exp 1", bus.dom_reset_o); end
        checks++; if (bus.pwr_ack_o !== 1'b0) begin errors++; $display("FAIL reset_pwr_ack got %b exp 0", bus.pwr_ack_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err_o); end
    endtask

    // stagger=2: sw_en 0001@T1, 0011@T4, 0111@T7, 1111@T10, SETTLE@T13
    task automatic test_rampup();
        logic [3:0] exp_sw [4];
        exp_sw[0] = 4'b0001; exp_sw[1] = 4'b0011; exp_sw[2] = 4'b0111; exp_sw[3] = 4'b1111;
        do_reset();
        bus.stagger_cfg_i = 8'd2;
        bus.settle_cfg_i  = 8'd5;
        bus.pwr_req_i     = 1'b1;
        tick();
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL rampup_busy_T1 got %b exp 1", bus.busy_o); end
        for (int k = 0; k < 4; k++) begin
            if (k != 0) begin
                tick(); tick();
                checks++; if (bus.sw_en_o !== exp_sw[k-1]) begin errors++; $display("FAIL rampup_hold_%0d sw_en got %b exp %b", k, bus.sw_en_o, exp_sw[k-1]); end
                tick();
            end
            checks++; if (bus.sw_en_o !== exp_sw[k]) begin errors++; $display("FAIL rampup_step_%0d sw_en got %b exp %b", k, bus.sw_en_o, exp_sw[k]); end
        end
        tick(); tick(); tick();
        checks++; if (bus.iso_en_o !== 1'b1) begin errors++; $display("FAIL rampup_T13_iso got %b exp 1", bus.iso_en_o); end
        bus.vdd_good_i = 1'b1;
        tick();
        checks++; if (bus.iso_en_o !== 1'b0) begin errors++; $display("FAIL rampup_T14_iso got %b exp 0", bus.iso_en_o); end
        checks++; if (bus.dom_reset_o !== 1'b1) begin errors++; $display("FAIL rampup_T14_dom_reset got %b exp 1", bus.dom_reset_o); end
        checks++; if (bus.pwr_ack_o !== 1'b0) begin errors++; $display("FAIL rampup_T14_ack got %b exp 0", bus.pwr_ack_o); end
`ifdef OH_PWRSEQ_RETENTION_EN
        tick();
        checks++; if (bus.ret_restore_o !== 1'b1) begin errors++; $display("FAIL restore_pulse got %b exp 1", bus.ret_restore_o); end
        checks++; if (bus.dom_reset_o !== 1'b1) begin errors++; $display("FAIL restore_dom_reset got %b exp 1", bus.dom_reset_o); end
`endif
        tick();
        checks++; if (bus.dom_reset_o !== 1'b0) begin errors++; $display("FAIL rampup_on_dom_reset got %b exp 0", bus.dom_reset_o); end
        checks++; if (bus.pwr_ack_o !== 1'b1) begin errors++; $display("FAIL rampup_on_ack got %b exp 1", bus.pwr_ack_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rampup_on_busy got %b exp 0", bus.busy_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL rampup_on_err got %b exp 0", bus.err_o); end
    endtask

    // Continues from ON left by test_rampup; stagger=0
    task automatic test_powerdown();
        logic [3:0] exp_sw [4];
        exp_sw[0] = 4'b0111; exp_sw[1] = 4'b0011; exp_sw[2] = 4'b0001; exp_sw[3] = 4'b0000;
        bus.stagger_cfg_i = 8'd0;
        bus.pwr_req_i     = 1'b0;
        tick();
        checks++; if (bus.iso_en_o !== 1'b1) begin errors++; $display("FAIL pdn_iso got %b exp 1", bus.iso_en_o); end
        checks++; if (bus.dom_reset_o !== 1'b1) begin errors++; $display("FAIL pdn_dom_reset got %b exp 1", bus.dom_reset_o); end
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL pdn_busy got %b exp 1", bus.busy_o); end
        checks++; if (bus.sw_en_o !== 4'b1111) begin errors++; $display("FAIL pdn_iso_sw_en got %b exp 1111", bus.sw_en_o); end
`ifdef OH_PWRSEQ_RETENTION_EN
        tick();
        checks++; if (bus.ret_save_o !== 1'b1) begin errors++; $display("FAIL save_pulse got %b exp 1", bus.ret_save_o); end
        tick();
        checks++; if (bus.ret_save_o !== 1'b0) begin errors++; $display("FAIL save_idle got %b exp 0", bus.ret_save_o); end
        checks++; if (bus.sw_en_o !== 4'b1111) begin errors++; $display("FAIL save_idle_sw_en got %b exp 1111", bus.sw_en_o); end
`endif
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (bus.sw_en_o !== exp_sw[k]) begin errors++; $display("FAIL pdn_step_%0d sw_en got %b exp %b", k, bus.sw_en_o, exp_sw[k]); end
            checks++; if (bus.pwr_ack_o !== 1'b1) begin errors++; $display("FAIL pdn_step_%0d ack got %b exp 1", k, bus.pwr_ack_o); end
        end
        tick();
        checks++; if (bus.pwr_ack_o !== 1'b0) begin errors++; $display("FAIL pdn_off_ack got %b exp 0", bus.pwr_ack_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL pdn_off_busy got %b exp 0", bus.busy_o); end
    endtask

    // stagger=0, settle=3, vdd_good stuck low: SETTLE T5..T8, err at T9, OFF at T13
    task automatic test_timeout();
        logic [3:0] exp_sw [13];
        logic       exp_err, exp_busy;
        exp_sw = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
                   4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b0000};
        do_reset();
        bus.stagger_cfg_i = 8'd0;
        bus.settle_cfg_i  = 8'd3;
        bus.pwr_req_i     = 1'b1;
        for (int t = 1; t <= 13; t++) begin
            tick();
            exp_err  = (t >= 9);
            exp_busy = (t <= 12);
            checks++; if (bus.sw_en_o !== exp_sw[t-1]) begin errors++; $display("FAIL timeout_T%0d sw_en got %b exp %b", t, bus.sw_en_o, exp_sw[t-1]); end
            checks++; if (bus.err_o !== exp_err) begin errors++; $display("FAIL timeout_T%0d err got %b exp %b", t, bus.err_o, exp_err); end
            checks++; if (bus.busy_o !== exp_busy) begin errors++; $display("FAIL timeout_T%0d busy got %b exp %b", t, bus.busy_o, exp_busy); end
            checks++; if (bus.pwr_ack_o !== 1'b0) begin errors++; $display("FAIL timeout_T%0d ack got %b exp 0", t, bus.pwr_ack_o); end
            checks++; if (bus.iso_en_o !== 1'b1 || bus.dom_reset_o !== 1'b1) begin errors++; $display("FAIL timeout_T%0d iso/dom_reset got %b%b exp 11", t, bus.iso_en_o, bus.dom_reset_o); end
        end
        tick(); tick(); tick();
        checks++; if (bus.busy_o !== 1'b0 || bus.err_o !== 1'b1) begin errors++; $display("FAIL timeout_no_retry busy/err got %b%b exp 01", bus.busy_o, bus.err_o); end
        bus.pwr_req_i = 1'b0;
        tick(); tick();
        bus.pwr_req_i = 1'b1;
        tick();
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL timeout_retry_err got %b exp 0", bus.err_o); end
        checks++; if (bus.sw_en_o !== 4'b0001) begin errors++; $display("FAIL timeout_retry_sw_en got %b exp 0001", bus.sw_en_o); end
    endtask

    // stagger=1: req pulses low in RAMPUP, ON still reached at T11, then powers down
    task automatic test_req_toggle();
        int n;
        int exp_n;
        do_reset();
        exp_n = 11;
`ifdef OH_PWRSEQ_RETENTION_EN
        exp_n = 12;
`endif
        bus.stagger_cfg_i = 8'd1;
        bus.settle_cfg_i  = 8'd2;
        bus.vdd_good_i    = 1'b1;
        bus.pwr_req_i     = 1'b1;
        tick();
        n = 1;
        bus.pwr_req_i = 1'b0;
        while (bus.pwr_ack_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n !== exp_n) begin errors++; $display("FAIL toggle_ack_cycle got %0d exp %0d", n, exp_n); end
        checks++; if (bus.dom_reset_o !== 1'b0) begin errors++; $display("FAIL toggle_on_dom_reset got %b exp 0", bus.dom_reset_o); end
        tick();
        checks++; if (bus.iso_en_o !== 1'b1 || bus.busy_o !== 1'b1) begin errors++; $display("FAIL toggle_iso iso/busy got %b%b exp 11", bus.iso_en_o, bus.busy_o); end
        n = 0;
        while (bus.busy_o !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL toggle_pdn_timeout busy got %b exp 0", bus.busy_o); end
        checks++; if (bus.pwr_ack_o !== 1'b0 || bus.sw_en_o !== 4'b0000) begin errors++; $display("FAIL toggle_off ack/sw_en got %b/%b exp 0/0000", bus.pwr_ack_o, bus.sw_en_o); end
    endtask

    // Reset asserted between clock edges with sw_en=0011
    task automatic test_async_reset();
        do_reset();
        bus.stagger_cfg_i = 8'd2;
        bus.pwr_req_i     = 1'b1;
        repeat (4) tick();
        checks++; if (bus.sw_en_o !== 4'b0011) begin errors++; $display("FAIL areset_pre sw_en got %b exp 0011", bus.sw_en_o); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.sw_en_o !== 4'b0000) begin errors++; $display("FAIL areset_sw_en got %b exp 0000", bus.sw_en_o); end
        checks++; if (bus.iso_en_o !== 1'b1 || bus.dom_reset_o !== 1'b1) begin errors++; $display("FAIL areset iso/dom_reset got %b%b exp 11", bus.iso_en_o, bus.dom_reset_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL areset_busy got %b exp 0", bus.busy_o); end
        bus.pwr_req_i = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_rampup();
        test_powerdown();
        test_timeout();
        test_req_toggle();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
